// File: rtl/unpool_layer_pkg.sv
// Shared definitions for the 2x un-pooling stage: default geometry, FSM state codes and width helper.
// The optional UNPOOL_ZERO_FILL_EN build is handled entirely in the top level.
package unpool_layer_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_IN_W   = 3;
    localparam int DEF_IN_H   = 3;
    localparam int DEF_OUT_W  = 2 * DEF_IN_W;
    localparam int DEF_OUT_H  = 2 * DEF_IN_H;

    typedef logic [1:0] unpool_state_t;

    localparam unpool_state_t ST_IDLE    = 2'd0;
    localparam unpool_state_t ST_CAPTURE = 2'd1;
    localparam unpool_state_t ST_EMIT    = 2'd2;
    localparam unpool_state_t ST_DONE    = 2'd3;

    function automatic int addr_w_for(input int n_items);
        return (n_items > 1) ? $clog2(n_items) : 1;
    endfunction

    localparam int DEF_ADDR_W = addr_w_for(DEF_OUT_W * DEF_OUT_H);

endpackage

// File: rtl/unpool_layer_addr_gen.sv
// Row/column scan counters for the up-sampled map, with last-beat flag and linear output address.
module unpool_addr_gen
    import unpool_layer_pkg::*;
#(
    parameter int OUT_W  = DEF_OUT_W,
    parameter int OUT_H  = DEF_OUT_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic row_end;
    logic col_end;

    assign col_end = (col == ADDR_W'(OUT_W - 1));
    assign row_end = (row == ADDR_W'(OUT_H - 1));
    assign last    = row_end & col_end;
    assign addr    = row * ADDR_W'(OUT_W) + col;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/unpool_layer.sv
// 2x un-pooling stage: captures an IN_H x IN_W map on start and streams the 2x up-sampled map row-major.
// Define UNPOOL_ZERO_FILL_EN for max-unpool style output (only even/even positions carry the source pixel).
module unpool_layer
    import unpool_layer_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int IN_H   = DEF_IN_H,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic signed [DATA_W-1:0]                 input_fm [IN_W*IN_H],
    output logic                                     busy,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic signed [DATA_W-1:0]                 out_data,
    output logic [addr_w_for(4*IN_W*IN_H)-1:0]       out_addr,
    output logic                                     out_last,
    output logic                                     done
);

    localparam int OUT_W  = 2 * IN_W;
    localparam int OUT_H  = 2 * IN_H;
    localparam int ADDR_W = addr_w_for(OUT_W * OUT_H);
    localparam int SRC_W  = addr_w_for(IN_W * IN_H);

    unpool_state_t            state;
    logic signed [DATA_W-1:0] fmap [IN_W*IN_H];
    logic [ADDR_W-1:0]        row;
    logic [ADDR_W-1:0]        col;
    logic [ADDR_W-1:0]        src_full;
    logic signed [DATA_W-1:0] pix;
    logic                     at_last;
    logic                     transfer;
    logic                     take_start;

    assign take_start = (state == ST_IDLE) && start;
    assign transfer   = out_valid & out_ready;
    assign busy       = (state == ST_CAPTURE) || (state == ST_EMIT);
    assign out_valid  = (state == ST_EMIT);
    assign done       = (state == ST_DONE);
    assign out_last   = out_valid & at_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start) state <= ST_CAPTURE;
                ST_CAPTURE: state <= ST_EMIT;
                ST_EMIT:    if (transfer && at_last) state <= ST_DONE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Map buffer is data only; it is rewritten on every accepted start.
    always_ff @(posedge clk) begin
        if (rst && take_start) begin
            fmap <= input_fm;
        end
    end

    unpool_addr_gen #(
        .OUT_W  (OUT_W),
        .OUT_H  (OUT_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_EMIT),
        .advance (transfer),
        .row     (row),
        .col     (col),
        .addr    (out_addr),
        .last    (at_last)
    );

    // Nearest-neighbour source pixel; data is forced to zero whenever no beat is presented.
    always_comb begin
        src_full = (row >> 1) * ADDR_W'(IN_W) + (col >> 1);
        pix      = fmap[src_full[SRC_W-1:0]];
`ifdef UNPOOL_ZERO_FILL_EN
        if (row[0] || col[0]) begin
            pix = '0;
        end
`else
`endif
        out_data = out_valid ? pix : '0;
    end

endmodule
